mips_fetch_stage: RTL

Instruction-fetch stage of the pipelined MIPS core, directly upstream of the IF/ID pipeline register.
- Owns the PC register and selects the next PC: sequential, branch, or jump.
- Issues requests to instruction memory over a req/gnt + rvalid handshake.
- Delivers InstrF and PCPlus4F to IF/ID, or a NOP bubble with zero PC when no valid instruction is available.

---
 rtl/mips_fetch_pkg.sv | 15 +
 rtl/mips_next_pc.sv | 21 ++
 rtl/mips_fetch_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mips_fetch_pkg.sv
// Shared types and constants for the MIPS instruction-fetch stage.
package mips_fetch_pkg;

   // Fetch handshake phases: issue request, wait for data, hold stalled data.
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2
   } fetch_state_t;

   localparam logic [31:0] PC_INC           = 32'd4;
   localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
   localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/mips_next_pc.sv
// Next-PC helper for the fetch stage: decode-stage redirect detection,
// target selection (jump beats branch) and the sequential PC+4 adder.
module mips_next_pc
   import mips_fetch_pkg::*;
(
   input  logic [31:0] pcf,
   input  logic        pcsrc,
   input  logic [31:0] pc_branch,
   input  logic        jump,
   input  logic [31:0] pc_jump,
   output logic        redirect,
   output logic [31:0] target,
   output logic [31:0] pc_plus4
);

   assign redirect = jump | pcsrc;
   assign target   = jump ? pc_jump : pc_branch;
   // Plain 32-bit add: 0xFFFF_FFFC rolls over to 0.
   assign pc_plus4 = pcf + PC_INC;

endmodule

// File: rtl/mips_fetch_stage.sv
// Instruction-fetch stage: owns PCF, drives the imem req/gnt + rvalid
// handshake with at most one request in flight, and presents either a
// valid instruction or a zero bubble to IF/ID.
// Optional macro FETCH_PERF_EN adds saturating fetch/kill counters.
module mips_fetch_stage
   import mips_fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
   parameter int          CNT_W    = 32
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              StallF,
   input  logic              PCSrcD,
   input  logic [31:0]       PCBranchD,
   input  logic              JumpD,
   input  logic [31:0]       PCJumpD,
   output logic              ImemReq,
   output logic [31:0]       ImemAddr,
   input  logic              ImemGnt,
   input  logic              ImemRvalid,
   input  logic [31:0]       ImemRdata,
   output logic [31:0]       InstrF,
   output logic [31:0]       PCPlus4F,
   output logic              InstrValidF
`ifdef FETCH_PERF_EN
   ,
   output logic [CNT_W-1:0]  FetchCntF,
   output logic [CNT_W-1:0]  KillCntF
`endif
);

   fetch_state_t state_reg, state_next;
   logic [31:0]  pcf_reg, pcf_next;
   logic         kill_reg, kill_next;
   logic [31:0]  buf_reg, buf_next;

   logic         redirect;
   logic [31:0]  target;
   logic [31:0]  pc_plus4;
   logic         valid_c;
   logic [31:0]  instr_c;

   mips_next_pc u_next_pc (
      .pcf       (pcf_reg),
      .pcsrc     (PCSrcD),
      .pc_branch (PCBranchD),
      .jump      (JumpD),
      .pc_jump   (PCJumpD),
      .redirect  (redirect),
      .target    (target),
      .pc_plus4  (pc_plus4)
   );

   // State, PC, kill flag and stall buffer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= S_REQ;
         pcf_reg   <= RESET_PC;
         kill_reg  <= 1'b0;
         buf_reg   <= NOP_INSTR;
      end else begin
         state_reg <= state_next;
         pcf_reg   <= pcf_next;
         kill_reg  <= kill_next;
         buf_reg   <= buf_next;
      end
   end

   // Next-state and handshake/output decode; a redirect always overrides StallF.
   always_comb begin
      state_next = state_reg;
      pcf_next   = pcf_reg;
      kill_next  = kill_reg;
      buf_next   = buf_reg;
      ImemReq    = 1'b0;
      valid_c    = 1'b0;
      instr_c    = NOP_INSTR;
      case (state_reg)
         S_REQ: begin
            ImemReq = 1'b1;
            // The address may move before grant; a redirect at grant time
            // marks the in-flight request as stale.
            if (redirect) pcf_next = target;
            if (ImemGnt) begin
               state_next = S_WAIT;
               kill_next  = redirect;
            end
         end
         S_WAIT: begin
            if (ImemRvalid) begin
               state_next = S_REQ;
               if (kill_reg || redirect) begin
                  kill_next = 1'b0;
                  if (redirect) pcf_next = target;
               end else begin
                  valid_c = 1'b1;
                  instr_c = ImemRdata;
                  if (!StallF) begin
                     pcf_next = pc_plus4;
                  end else begin
                     buf_next   = ImemRdata;
                     state_next = S_HOLD;
                  end
               end
            end else if (redirect) begin
               pcf_next  = target;
               kill_next = 1'b1;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pcf_next   = target;
               state_next = S_REQ;
            end else begin
               valid_c = 1'b1;
               instr_c = buf_reg;
               if (!StallF) begin
                  pcf_next   = pc_plus4;
                  state_next = S_REQ;
               end
            end
         end
         default: state_next = S_REQ;
      endcase
   end

   assign ImemAddr    = pcf_reg;
   assign InstrValidF = valid_c;
   assign InstrF      = valid_c ? instr_c : NOP_INSTR;
   assign PCPlus4F    = valid_c ? pc_plus4 : 32'h0;

`ifdef FETCH_PERF_EN
   logic             accept;
   logic             drop;
   logic [CNT_W-1:0] fetch_cnt_reg;
   logic [CNT_W-1:0] kill_cnt_reg;
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   // An instruction leaves for IF/ID; a response is thrown away in S_WAIT.
   assign accept = valid_c & ~StallF;
   assign drop   = (state_reg == S_WAIT) & ImemRvalid & (kill_reg | redirect);

   // Saturating performance counters.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fetch_cnt_reg <= '0;
         kill_cnt_reg  <= '0;
      end else begin
         if (accept && (fetch_cnt_reg != '1)) fetch_cnt_reg <= fetch_cnt_reg + CNT_ONE;
         if (drop && (kill_cnt_reg != '1))    kill_cnt_reg  <= kill_cnt_reg + CNT_ONE;
      end
   end

   assign FetchCntF = fetch_cnt_reg;
   assign KillCntF  = kill_cnt_reg;
`endif

endmodule
